// File: rtl/lfsr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_seq_ctrl
//   Sequencer around a 32-bit Fibonacci LFSR (taps 31,29,25,24 XORed into
//   bit 0, shift left). A start command loads a seed and a word count; the
//   block then streams that many successive LFSR states over a valid/ready
//   interface. An all-zero seed is replaced by SEED_DEFAULT so the register
//   can never lock up. A run can be cut short with abort.
//
//   Optional feature macro: LFSR_SIG_EN
//     defined   -> port sig present; XOR signature of every transferred word
//     undefined -> sig port and its logic are absent
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   rst        in   1      synchronous active-high reset, overrides all inputs
//   start      in   1      command strobe, accepted only in IDLE
//   seed       in   32     seed, sampled with an accepted start
//   count      in   CNT_W  words to emit, sampled with an accepted start
//   abort      in   1      end the current run and return to IDLE
//   out_data   out  32     current LFSR state
//   out_valid  out  1      out_data valid
//   out_ready  in   1      sink accepts out_data when out_valid & out_ready
//   busy       out  1      high whenever the FSM is not in IDLE
//   done       out  1      one-cycle pulse on normal completion
//   sig        out  32     XOR signature of emitted words (LFSR_SIG_EN only)
// -----------------------------------------------------------------------------
module lfsr_seq_ctrl #(
  parameter logic [31:0] SEED_DEFAULT = 32'h1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
`ifdef LFSR_SIG_EN
  ,
  output logic [31:0]      sig
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_nxt;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic             xfer;

  assign lfsr_nxt = {lfsr[30:0], lfsr[31] ^ lfsr[29] ^ lfsr[25] ^ lfsr[24]};
  assign out_data = lfsr;

  // Next-state and output decode. A transfer is suppressed when abort is
  // high so the LFSR and counter are left untouched by an aborted cycle.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (out_ready) begin
          xfer = 1'b1;
          // Leaving at remaining==1 keeps the counter from ever wrapping.
          if (remaining == CNT_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = ~abort;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, LFSR and remaining-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED_DEFAULT;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lfsr      <= (seed == 32'h0) ? SEED_DEFAULT : seed;
        remaining <= count;
      end else if (xfer) begin
        lfsr      <= lfsr_nxt;
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

`ifdef LFSR_SIG_EN
  // Signature accumulates every transferred word and holds after the run
  // ends, so it can be read any time before the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= 32'h0;
    end else if (accept) begin
      sig <= 32'h0;
    end else if (xfer) begin
      sig <= sig ^ lfsr;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lfsr_seq_ctrl
//   Scoreboard bench for lfsr_seq_ctrl. applyStimulus issues a start and pushes
//   the words a reference LFSR model predicts; a negedge monitor pops and
//   compares on every transfer. checkOutput does all comparisons.
// -----------------------------------------------------------------------------
module tb_lfsr_seq_ctrl;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [31:0]      seed;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
`ifdef LFSR_SIG_EN
  logic [31:0]      sig;
`endif

  int          compared   = 0;
  int          mismatched = 0;
  int          done_cnt   = 0;
  int          xfer_cnt   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sig_model;
  logic        prev_stall;
  logic [31:0] prev_data;

  lfsr_seq_ctrl #(.SEED_DEFAULT(32'h1), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .count     (count),
    .abort     (abort),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef LFSR_SIG_EN
    ,
    .sig       (sig)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next-state of the Fibonacci LFSR.
  function automatic logic [31:0] lfsrStep(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[29] ^ x[25] ^ x[24]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one start command and predict its word stream. Called just after a
  // posedge; returns just after the posedge where the start was accepted.
  task automatic applyStimulus(input logic [31:0] s, input int cnt);
    logic [31:0] x;
    x = (s == 32'h0) ? 32'h1 : s;
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back(x);
      x = lfsrStep(x);
    end
    sig_model = 32'h0;
    start = 1'b1;
    seed  = s;
    count = CNT_W'(cnt);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    if (busy) checkOutput("timeout", 32'd1, 32'd0);
  endtask

  // Monitor: compare every real transfer against the scoreboard and check
  // that out_data holds steady across back-pressure.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_stall && out_valid) checkOutput("hold", out_data, prev_data);
      if (out_valid && out_ready && !abort) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_word", out_data, 32'hDEAD_BEEF ^ out_data);
        end else begin
          checkOutput("word", out_data, exp_q.pop_front());
          sig_model = sig_model ^ out_data;
        end
      end
      prev_stall <= out_valid && !out_ready && !abort;
      prev_data  <= out_data;
    end
  end

  int d0;
  int x0;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    seed      = 32'h0;
    count     = '0;
    abort     = 1'b0;
    out_ready = 1'b1;
    sig_model = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_busy",  {31'b0, busy},      32'd0);
    checkOutput("rst_done",  {31'b0, done},      32'd0);
    checkOutput("rst_data",  out_data,           32'h1);
`ifdef LFSR_SIG_EN
    checkOutput("rst_sig", sig, 32'h0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // 1) seed 1, count 3, sink always ready
    d0 = done_cnt; x0 = xfer_cnt;
    applyStimulus(32'h1, 3);
    waitIdle(20);
    checkOutput("t1_xfers", 32'(xfer_cnt - x0), 32'd3);
    checkOutput("t1_done",  32'(done_cnt - d0), 32'd1);
    checkOutput("t1_left",  32'(exp_q.size()), 32'd0);
`ifdef LFSR_SIG_EN
    checkOutput("t1_sig", sig, 32'h7);
    checkOutput("t1_sig_model", sig, sig_model);
`endif

    // 2) zero seed falls back to the default seed
    @(posedge clk); #1;
    d0 = done_cnt; x0 = xfer_cnt;
    applyStimulus(32'h0, 1);
    waitIdle(20);
    checkOutput("t2_xfers", 32'(xfer_cnt - x0), 32'd1);
    checkOutput("t2_done",  32'(done_cnt - d0), 32'd1);

    // 3) top bit feeds back into bit 0
    @(posedge clk); #1;
    x0 = xfer_cnt;
    applyStimulus(32'h8000_0000, 2);
    waitIdle(20);
    checkOutput("t3_xfers", 32'(xfer_cnt - x0), 32'd2);
    checkOutput("t3_lfsr_post", out_data, 32'h2);

    // 4) back-pressure pattern 1,0,0,1,1,0,1
    @(posedge clk); #1;
    d0 = done_cnt; x0 = xfer_cnt;
    applyStimulus(32'h1, 4);
    begin
      logic [6:0] pat;
      pat = 7'b1011001;
      for (int i = 0; i < 7; i++) begin
        out_ready = pat[i];
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    waitIdle(20);
    checkOutput("t4_xfers", 32'(xfer_cnt - x0), 32'd4);
    checkOutput("t4_done",  32'(done_cnt - d0), 32'd1);

    // 5) abort after the third transfer, then restart immediately
    @(posedge clk); #1;
    d0 = done_cnt; x0 = xfer_cnt;
    applyStimulus(32'h1, 10);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checkOutput("t5_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("t5_busy",  {31'b0, busy},      32'd0);
    checkOutput("t5_xfers", 32'(xfer_cnt - x0), 32'd3);
    checkOutput("t5_data",  out_data,           32'h8);
    checkOutput("t5_nodone", 32'(done_cnt - d0), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    x0 = xfer_cnt;
    applyStimulus(32'h0000_0005, 2);
    waitIdle(20);
    checkOutput("t5_restart", 32'(xfer_cnt - x0), 32'd2);

    // 6a) zero count: no words, just a done pulse
    @(posedge clk); #1;
    d0 = done_cnt; x0 = xfer_cnt;
    applyStimulus(32'h1234_5678, 0);
    @(negedge clk);
    checkOutput("t6_done",  {31'b0, done},      32'd1);
    checkOutput("t6_valid", {31'b0, out_valid}, 32'd0);
    waitIdle(20);
    checkOutput("t6_xfers", 32'(xfer_cnt - x0), 32'd0);

    // 6b) reset in the middle of a run
    @(posedge clk); #1;
    applyStimulus(32'h0F0F_0F0F, 8);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("t6_rst_busy",  {31'b0, busy},      32'd0);
    checkOutput("t6_rst_done",  {31'b0, done},      32'd0);
    checkOutput("t6_rst_data",  out_data,           32'h1);
`ifdef LFSR_SIG_EN
    checkOutput("t6_rst_sig", sig, 32'h0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
